// File: rtl/reciprocal_float_arbiter.sv
// Round-robin arbiter sharing one reciprocal_float core among NREQ requesters, one operation at a time.
// Optional watchdog abort is built when RECIP_ARB_TIMEOUT_EN is defined.
module reciprocal_float_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int TO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_zero,
  output logic                 rsp_timeout,
  input  logic                 rsp_ready,
  output logic                 core_start,
  output logic [31:0]          core_x,
  input  logic [31:0]          core_out,
  input  logic                 core_done,
  input  logic                 core_zero_flag,
  output logic                 core_rst
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
  // req_ready is a one-cycle grant pulse; rsp_valid and its payload hold until rsp_ready.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, gid, gnt;
  logic [31:0]    x_sel;
  logic           any_req;
  logic           timeout_hit;

  assign any_req = |req_valid;

  // Lowest set bit overall, overridden by the lowest set bit at or after ptr.
  always_comb begin
    gnt = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (req_valid[i]) gnt = IDW'(i);
    for (int i = NREQ-1; i >= 0; i--)
      if (req_valid[i] && (IDW'(i) >= ptr)) gnt = IDW'(i);
  end

  always_comb begin
    x_sel     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) x_sel = req_x[32*i +: 32];
      req_ready[i] = (state == IDLE) && !rst && any_req && (gnt == IDW'(i));
    end
  end

  assign core_start = (state == ISSUE) && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (core_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gid       <= '0;
      core_x    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          core_x <= x_sel;
          gid    <= gnt;
        end
        WAIT: if (core_done) begin
          rsp_valid <= 1'b1;
          rsp_id    <= gid;
          rsp_data  <= core_out;
          rsp_zero  <= core_zero_flag;
        end else if (timeout_hit) begin
          rsp_valid <= 1'b1;
          rsp_id    <= gid;
          rsp_data  <= '0;
          rsp_zero  <= 1'b0;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr       <= (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RECIP_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;

  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state != WAIT)) wd_cnt <= '0;
    else                        wd_cnt <= wd_cnt + 1'b1;
  end

  // Fires on the TO_CYC-th WAIT cycle; core_done on that same cycle still wins.
  assign timeout_hit = (state == WAIT) && !core_done && (wd_cnt == CW'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst)                                rsp_timeout <= 1'b0;
    else if ((state == WAIT) && core_done)  rsp_timeout <= 1'b0;
    else if (timeout_hit)                   rsp_timeout <= 1'b1;
  end
`else
  // Watchdog absent: the comparison is constant false and keeps TO_CYC referenced.
  assign timeout_hit = (TO_CYC < 0);
  assign rsp_timeout = 1'b0;
`endif

  assign core_rst = rst | timeout_hit;

endmodule

// File: tb/tb_reciprocal_float_arbiter.sv
// Scoreboard bench for reciprocal_float_arbiter with a behavioural core model answering from a small table.
module tb_reciprocal_float_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 2 + IDW + 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid, rsp_zero, rsp_timeout, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               core_start, core_done, core_zero_flag, core_rst;
  logic [31:0]        core_x, core_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0]   exp_q[$];
  logic [IDW-1:0] gnt_q[$];
  int             grant_cnt = 0;
  int             cyc = 0;
  int             grant_cyc = 0;
  logic [NREQ-1:0] acc_mask = '0;
  logic [NREQ-1:0] hold_mask;
  logic           prev_grant = 1'b0;
  int             core_lat;
  bit             core_hang;

  reciprocal_float_arbiter #(.NREQ(NREQ), .IDW(IDW), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready), .core_start(core_start), .core_x(core_x),
    .core_out(core_out), .core_done(core_done), .core_zero_flag(core_zero_flag), .core_rst(core_rst)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic to, input logic z, input logic [IDW-1:0] id,
                                        input logic [31:0] d);
    return {to, z, id, d};
  endfunction

  function automatic logic [31:0] recip(input logic [31:0] x);
    if (x[30:0] == 31'd0) return {x[31], 31'h7F800000};
    case (x)
      32'h40000000: return 32'h3F000000;
      32'h40800000: return 32'h3E800000;
      32'h3F000000: return 32'h40000000;
      32'h3F800000: return 32'h3F800000;
      32'hC0000000: return 32'hBF000000;
      32'h3E800000: return 32'h40800000;
      32'h40400000: return 32'h3EAAAAAB;
      32'hBF800000: return 32'hBF800000;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(acc_mask & ~hold_mask);
    end
  endtask

  task automatic req(input int i, input logic [31:0] x);
    req_x[32*i +: 32] = x;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_rsp_valid(input string name, input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin step(1); n++; end
    chk(name, rsp_valid, 1'b1);
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (!core_start && n < budget) begin step(1); n++; end
    chk(name, core_start, 1'b1);
  endtask

  task automatic wait_grants(input string name, input int target, input int budget);
    int n = 0;
    while (grant_cnt < target && n < budget) begin step(1); n++; end
    chk(name, grant_cnt, target);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < budget) begin step(1); n++; end
    chk({name, "_rsp_drained"}, exp_q.size(), 0);
    chk({name, "_gnt_drained"}, gnt_q.size(), 0);
  endtask

  // ---------------- core model ----------------
  initial begin
    logic        busy;
    int          cnt;
    logic [31:0] hx;
    busy = 1'b0; cnt = 0; hx = '0;
    core_done = 1'b0; core_out = '0; core_zero_flag = 1'b0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst || core_rst) busy = 1'b0;
      else if (busy) begin
        chk("core_x_stable", core_x, hx);
        if (!core_hang) begin
          cnt--;
          if (cnt == 0) begin
            core_done      = 1'b1;
            core_out       = recip(hx);
            core_zero_flag = (hx[30:0] == 31'd0);
            busy           = 1'b0;
          end
        end
      end
      if (core_start && !rst) begin
        busy = 1'b1; hx = core_x; cnt = core_lat;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int gidx;
    forever begin
      @(negedge clk);
      cyc++;
      chk("core_start_after_grant", core_start, prev_grant);
      acc_mask = req_valid & req_ready;
      if (req_ready != '0) begin
        chk("req_ready_onehot", $countones(req_ready), 1);
        chk("req_ready_in_valid", req_ready & ~req_valid, 0);
        grant_cnt++;
        grant_cyc = cyc;
        gidx = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx = i;
        if (gnt_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_grant: got id %0d expected none at %0t", gidx, $time);
        end else chk("grant_id", gidx, gnt_q.pop_front());
      end
      prev_grant = (req_ready != '0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rsp: got %0h expected none at %0t",
                   {rsp_timeout, rsp_zero, rsp_id, rsp_data}, $time);
        end else chk("rsp", {rsp_timeout, rsp_zero, rsp_id, rsp_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    n_checks++; n_fail++;
    $display("FAIL global_timeout: got running expected finished at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] snap;
    rst = 1'b1; req_valid = '0; req_x = '0; rsp_ready = 1'b1;
    hold_mask = '0; core_lat = 20; core_hang = 1'b0;
    step(3);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_core_rst", core_rst, 1);
    rst = 1'b0;
    step(1);
    chk("idle_core_rst", core_rst, 0);

    // single request, 2.0 -> 0.5, latency 2 + 20
    gnt_q.push_back(2'd0);
    exp_q.push_back(pack(1'b0, 1'b0, 2'd0, 32'h3F000000));
    req(0, 32'h40000000);
    wait_rsp_valid("t1_rsp_valid", 60);
    chk("t1_latency", cyc + 1 - grant_cyc, 22);
    wait_drain("t1", 20);

    // fairness from ptr 0 with everyone holding req_valid
    rst = 1'b1; step(2); rst = 1'b0;
    core_lat = 3; hold_mask = 4'b1111;
    req(0, 32'h40000000); req(1, 32'h40800000); req(2, 32'h3F000000); req(3, 32'h3F800000);
    gnt_q.push_back(2'd0); gnt_q.push_back(2'd1); gnt_q.push_back(2'd2);
    gnt_q.push_back(2'd3); gnt_q.push_back(2'd0);
    exp_q.push_back(pack(1'b0, 1'b0, 2'd0, 32'h3F000000));
    exp_q.push_back(pack(1'b0, 1'b0, 2'd1, 32'h3E800000));
    exp_q.push_back(pack(1'b0, 1'b0, 2'd2, 32'h40000000));
    exp_q.push_back(pack(1'b0, 1'b0, 2'd3, 32'h3F800000));
    exp_q.push_back(pack(1'b0, 1'b0, 2'd0, 32'h3F000000));
    wait_grants("t2_grants", grant_cnt + 5, 100);
    req_valid = '0; hold_mask = '0;
    wait_drain("t2", 40);

    // backpressure: ptr is 1, so requester 2 then 3
    core_lat = 4; rsp_ready = 1'b0;
    req(2, 32'hC0000000); req(3, 32'h3E800000);
    gnt_q.push_back(2'd2); gnt_q.push_back(2'd3);
    exp_q.push_back(pack(1'b0, 1'b0, 2'd2, 32'hBF000000));
    exp_q.push_back(pack(1'b0, 1'b0, 2'd3, 32'h40800000));
    wait_rsp_valid("t3_rsp_valid", 30);
    snap = {rsp_timeout, rsp_zero, rsp_id, rsp_data};
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("t3_rsp_hold", {rsp_timeout, rsp_zero, rsp_id, rsp_data}, snap);
      chk("t3_rsp_valid_hold", rsp_valid, 1'b1);
      chk("t3_no_grant", req_ready, 0);
      chk("t3_no_start", core_start, 0);
    end
    rsp_ready = 1'b1;
    step(1);
    chk("t3_next_grant", req_ready, 4'b1000);
    wait_drain("t3", 40);

    // zero operands: -0 on requester 1, +0 on requester 2 (ptr is 0)
    core_lat = 5;
    req(1, 32'h80000000); req(2, 32'h00000000);
    gnt_q.push_back(2'd1); gnt_q.push_back(2'd2);
    exp_q.push_back(pack(1'b0, 1'b1, 2'd1, 32'hFF800000));
    exp_q.push_back(pack(1'b0, 1'b1, 2'd2, 32'h7F800000));
    wait_drain("t4", 60);

    // reset while in WAIT; ptr was 3 and must return to 0
    core_lat = 20;
    req(2, 32'h40000000);
    gnt_q.push_back(2'd2);
    wait_start("t5_start", 20);
    step(5);
    rst = 1'b1;
    step(1);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_rsp_zero", rsp_zero, 0);
    chk("t5_core_start", core_start, 0);
    chk("t5_core_x", core_x, 0);
    chk("t5_core_rst", core_rst, 1);
    chk("t5_req_ready", req_ready, 0);
    rst = 1'b0;
    step(30);
    chk("t5_no_rsp", rsp_valid, 0);
    core_lat = 3;
    req(0, 32'h40400000); req(3, 32'hBF800000);
    gnt_q.push_back(2'd0); gnt_q.push_back(2'd3);
    exp_q.push_back(pack(1'b0, 1'b0, 2'd0, 32'h3EAAAAAB));
    exp_q.push_back(pack(1'b0, 1'b0, 2'd3, 32'hBF800000));
    wait_drain("t5", 40);

`ifdef RECIP_ARB_TIMEOUT_EN
    // watchdog: core never finishes, abort on the 16th WAIT cycle
    core_hang = 1'b1;
    req(0, 32'h40000000);
    gnt_q.push_back(2'd0);
    exp_q.push_back(pack(1'b1, 1'b0, 2'd0, 32'h00000000));
    wait_start("t6_start", 20);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk("t6_core_rst", core_rst, (k == 16));
    end
    step(1);
    chk("t6_rsp_valid", rsp_valid, 1'b1);
    wait_drain("t6", 20);
    core_hang = 1'b0;
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
